// File: rtl/pos_enc_pkg.sv
// Shared definitions for the positional-embedding ROM row arbiter:
// FSM state encoding, default geometry of the embedding ROM and a
// width helper used to size requester-id fields.
package pos_enc_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int NUM_TOKENS = 196;
    localparam int E          = 128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } arb_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req_i  N-bit request vector
//   ptr_i  index searched first; the scan wraps modulo N
//   gnt_o  one-hot grant (all zero when no request is set)
//   idx_o  encoded index of the granted bit (0 when no request)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        logic found;
        int   c;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr_i) + i) % N;
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/pos_rom_row_arbiter.sv
// Shares one synchronous positional-embedding ROM (1-cycle read latency)
// among NUM_REQ requesters. Each accepted request streams a full token row
// (E values) from the ROM and returns it as a tagged response stream.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_token/req_ready   per-requester row request handshake
//   rom_token_idx/rom_dim           ROM row/column address (0 outside bursts)
//   rom_pos_val                     ROM data, one cycle after the address
//   rsp_valid/id/dim/data/last/err  response beat stream, no backpressure
//   busy                            high whenever the FSM is not idle
module pos_rom_row_arbiter #(
    parameter  int DATA_WIDTH = pos_enc_pkg::DATA_WIDTH,
    parameter  int NUM_TOKENS = pos_enc_pkg::NUM_TOKENS,
    parameter  int E          = pos_enc_pkg::E,
    parameter  int NUM_REQ    = 4,
    localparam int TOK_W      = $clog2(NUM_TOKENS),
    localparam int DIM_W      = $clog2(E),
    localparam int ID_W       = pos_enc_pkg::id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*TOK_W-1:0] req_token,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [TOK_W-1:0]         rom_token_idx,
    output logic [DIM_W-1:0]         rom_dim,
    input  logic [DATA_WIDTH-1:0]    rom_pos_val,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DIM_W-1:0]         rsp_dim,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_last,
    output logic                     rsp_err,
    output logic                     busy
);

    import pos_enc_pkg::*;

    // One extra bit so the range check also works when NUM_TOKENS is 2**TOK_W.
    localparam logic [TOK_W:0]   TOK_LIMIT = (TOK_W+1)'(NUM_TOKENS);
    localparam logic [DIM_W-1:0] DIM_LAST  = DIM_W'(E-1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_REQ-1);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [TOK_W-1:0]  tok_q, tok_d;
    logic [DIM_W-1:0]  dim_q, dim_d;
    logic              issue_vld_q, issue_vld_d;
    logic [DIM_W-1:0]  dim_dly_q, dim_dly_d;
    logic [ID_W-1:0]   id_dly_q, id_dly_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    win_idx;
    logic [TOK_W-1:0]   win_tok;
    logic               in_err;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx)
    );

    assign win_tok = req_token[win_idx*TOK_W +: TOK_W];
    assign in_err  = (state_q == S_ERR);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        tok_d         = tok_q;
        dim_d         = dim_q;
        issue_vld_d   = 1'b0;
        dim_dly_d     = dim_dly_q;
        id_dly_d      = id_dly_q;
        req_ready     = '0;
        rom_token_idx = '0;
        rom_dim       = '0;
        case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    // The grant is combinational; keep it quiet while reset is held.
                    if (rst_n) begin
                        req_ready = gnt;
                    end
                    tok_d    = win_tok;
                    id_d     = win_idx;
                    rr_ptr_d = (win_idx == ID_LAST) ? '0 : win_idx + 1'b1;
                    dim_d    = '0;
                    state_d  = ({1'b0, win_tok} < TOK_LIMIT) ? S_BURST : S_ERR;
                end
            end
            S_BURST: begin
                rom_token_idx = tok_q;
                rom_dim       = dim_q;
                // Tag travels one cycle behind the address to meet the ROM data.
                issue_vld_d   = 1'b1;
                dim_dly_d     = dim_q;
                id_dly_d      = id_q;
                dim_d         = dim_q + 1'b1;
                if (dim_q == DIM_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            tok_q       <= '0;
            dim_q       <= '0;
            issue_vld_q <= 1'b0;
            dim_dly_q   <= '0;
            id_dly_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            tok_q       <= tok_d;
            dim_q       <= dim_d;
            issue_vld_q <= issue_vld_d;
            dim_dly_q   <= dim_dly_d;
            id_dly_q    <= id_dly_d;
        end
    end

    // Error beats come straight from the FSM; data beats from the delayed tag.
    assign rsp_valid = issue_vld_q | in_err;
    assign rsp_err   = in_err;
    assign rsp_id    = issue_vld_q ? id_dly_q : (in_err ? id_q : '0);
    assign rsp_dim   = issue_vld_q ? dim_dly_q : '0;
    assign rsp_data  = issue_vld_q ? rom_pos_val : '0;
    assign rsp_last  = in_err | (issue_vld_q & (dim_dly_q == DIM_LAST));
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pos_rom_row_arbiter.sv
module tb_pos_rom_row_arbiter;
    import pos_enc_pkg::*;

    localparam int NR   = 4;
    localparam int TW   = 8;
    localparam int DW   = 7;
    localparam int IW   = 2;
    localparam int NTOK = 196;
    localparam int ROWL = 128;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] dim;
        logic [15:0]   data;
        logic          last;
        logic          err;
        int            cyc;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*TW-1:0] req_token = '0;
    logic [NR-1:0]    req_ready;
    logic [TW-1:0]    rom_token_idx;
    logic [DW-1:0]    rom_dim;
    logic [15:0]      rom_pos_val = '0;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_dim;
    logic [15:0]      rsp_data;
    logic             rsp_last;
    logic             rsp_err;
    logic             busy;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    beat_t q[$];

    pos_rom_row_arbiter #(
        .DATA_WIDTH (16),
        .NUM_TOKENS (NTOK),
        .E          (ROWL),
        .NUM_REQ    (NR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_token     (req_token),
        .req_ready     (req_ready),
        .rom_token_idx (rom_token_idx),
        .rom_dim       (rom_dim),
        .rom_pos_val   (rom_pos_val),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_dim       (rsp_dim),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: word = {token, dim}, one cycle latency.
    always @(posedge clk) rom_pos_val <= {1'b0, rom_token_idx, rom_dim};

    // Scoreboard consumer: every response beat must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected got id=%0d dim=%0d data=%h last=%b err=%b cyc=%0d required none",
                             rsp_id, rsp_dim, rsp_data, rsp_last, rsp_err, cyc);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    if ({rsp_id, rsp_dim, rsp_data, rsp_last, rsp_err} !== {e.id, e.dim, e.data, e.last, e.err}
                        || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL beat got id=%0d dim=%0d data=%h last=%b err=%b cyc=%0d required id=%0d dim=%0d data=%h last=%b err=%b cyc=%0d",
                                 rsp_id, rsp_dim, rsp_data, rsp_last, rsp_err, cyc,
                                 e.id, e.dim, e.data, e.last, e.err, e.cyc);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                beat_t e;
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL beat_missing got no beat required id=%0d dim=%0d cyc=%0d", e.id, e.dim, e.cyc);
            end
        end
    end

    task automatic push_row(input int id, input int tok, input int t);
        beat_t b;
        if (tok < NTOK) begin
            for (int d = 0; d < ROWL; d++) begin
                b.id   = IW'(id);
                b.dim  = DW'(d);
                b.data = 16'((tok << 7) | d);
                b.last = (d == ROWL - 1);
                b.err  = 1'b0;
                b.cyc  = t + 2 + d;
                q.push_back(b);
            end
        end else begin
            b.id   = IW'(id);
            b.dim  = '0;
            b.data = '0;
            b.last = 1'b1;
            b.err  = 1'b1;
            b.cyc  = t + 1;
            q.push_back(b);
        end
    endtask

    task automatic wait_grant(input int budget, output logic [NR-1:0] g, output int t);
        g = '0;
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                g = req_ready;
                t = cyc;
                break;
            end
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_valid = '0;
        req_token = '0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_tok(input int r, input int tok);
        req_token[r*TW +: TW] = TW'(tok);
    endtask

    task automatic test_reset;
        logic [NR-1:0] g;
        req_valid = 4'hF;
        set_tok(0, 3);
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rom_token_idx, rom_dim, rsp_valid, rsp_id, rsp_dim, rsp_data, rsp_last, rsp_err, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b tok=%0d dim=%0d vld=%b busy=%b required all 0",
                     req_ready, rom_token_idx, rom_dim, rsp_valid, busy);
        end
        checks++;
        if (dut.state_q !== S_IDLE || dut.rr_ptr_q !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got state=%0d rr_ptr=%0d required 0/0", dut.state_q, dut.rr_ptr_q);
        end
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        g = req_ready;
        checks++;
        if (g !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req got ready=%b busy=%b required 0000/0", g, busy);
        end
    endtask

    task automatic test_single;
        logic [NR-1:0] g;
        int t, tdrv;
        @(posedge clk);
        #1;
        set_tok(0, 5);
        req_valid[0] = 1'b1;
        tdrv = cyc;
        wait_grant(10, g, t);
        checks++;
        if (g !== 4'b0001 || t != tdrv) begin
            failures++;
            $display("FAIL single_grant got ready=%b cyc=%0d required 0001 cyc=%0d", g, t, tdrv);
        end
        push_row(0, 5, t);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        while (cyc < t + ROWL + 1) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy_last got %b required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || q.size() != 0) begin
            failures++;
            $display("FAIL single_done got busy=%b pending=%0d required 0/0", busy, q.size());
        end
    endtask

    task automatic test_four_simultaneous;
        logic [NR-1:0] g;
        int t, prev;
        bit ok;
        do_reset();
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) set_tok(r, 10 * (r + 1));
        req_valid = 4'hF;
        prev = -1;
        for (int k = 0; k < NR; k++) begin
            wait_grant(300, g, t);
            checks++;
            if (g !== NR'(1 << k) || (k > 0 && t - prev != ROWL + 2)) begin
                failures++;
                $display("FAIL four_grant%0d got ready=%b gap=%0d required %b gap=%0d",
                         k, g, t - prev, NR'(1 << k), ROWL + 2);
            end
            push_row(k, 10 * (k + 1), t);
            prev = t;
            @(posedge clk);
            #1 req_valid[k] = 1'b0;
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL four_drain got pending=%0d busy=%b required 0/0", q.size(), busy);
        end
    endtask

    task automatic test_fairness;
        logic [NR-1:0] g;
        int t, w, ep;
        bit ok;
        do_reset();
        @(posedge clk);
        #1;
        set_tok(1, 100);
        set_tok(3, 150);
        req_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            w = (k % 2 == 0) ? 1 : 3;
            wait_grant(300, g, t);
            checks++;
            if (g !== NR'(1 << w)) begin
                failures++;
                $display("FAIL fair_grant%0d got ready=%b required %b", k, g, NR'(1 << w));
            end
            push_row(w, (w == 1) ? 100 : 150, t);
            @(posedge clk);
            #1;
            ep = (w + 1) % NR;
            checks++;
            if (dut.rr_ptr_q !== IW'(ep)) begin
                failures++;
                $display("FAIL fair_ptr%0d got %0d required %0d", k, dut.rr_ptr_q, ep);
            end
            if (k == 5) req_valid = '0;
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fair_drain got pending=%0d busy=%b required 0/0", q.size(), busy);
        end
    endtask

    task automatic test_error_boundary;
        logic [NR-1:0] g;
        int t, t2;
        bit ok;
        do_reset();
        @(posedge clk);
        #1;
        set_tok(2, 196);
        set_tok(3, 195);
        req_valid = 4'b1100;
        wait_grant(10, g, t);
        checks++;
        if (g !== 4'b0100) begin
            failures++;
            $display("FAIL err_grant got ready=%b required 0100", g);
        end
        push_row(2, 196, t);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_token_idx !== '0 || rom_dim !== '0) begin
            failures++;
            $display("FAIL err_rom_addr got tok=%0d dim=%0d required 0/0", rom_token_idx, rom_dim);
        end
        wait_grant(10, g, t2);
        checks++;
        if (g !== 4'b1000 || t2 != t + 2) begin
            failures++;
            $display("FAIL err_next_grant got ready=%b cyc=%0d required 1000 cyc=%0d", g, t2, t + 2);
        end
        push_row(3, 195, t2);
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        for (int d = 0; d < ROWL; d++) begin
            @(negedge clk);
            checks++;
            if (rom_token_idx !== 8'd195 || rom_dim !== DW'(d)) begin
                failures++;
                $display("FAIL bound_addr got tok=%0d dim=%0d required 195/%0d", rom_token_idx, rom_dim, d);
            end
        end
        @(negedge clk);
        checks++;
        if (rom_token_idx !== '0) begin
            failures++;
            $display("FAIL bound_addr_drain got %0d required 0", rom_token_idx);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bound_drain got pending=%0d busy=%b required 0/0", q.size(), busy);
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [NR-1:0] g;
        int t;
        bit ok;
        do_reset();
        @(posedge clk);
        #1;
        set_tok(0, 7);
        set_tok(2, 9);
        req_valid = 4'b0101;
        wait_grant(10, g, t);
        checks++;
        if (g !== 4'b0001) begin
            failures++;
            $display("FAIL rst_first_grant got ready=%b required 0001", g);
        end
        push_row(0, 7, t);
        while (cyc < t + 52) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        q.delete();
        checks++;
        if ({req_ready, rom_token_idx, rom_dim, rsp_valid, rsp_id, rsp_dim, rsp_data, rsp_last, rsp_err, busy} !== '0) begin
            failures++;
            $display("FAIL rst_async_outputs got ready=%b tok=%0d vld=%b last=%b busy=%b required all 0",
                     req_ready, rom_token_idx, rsp_valid, rsp_last, busy);
        end
        checks++;
        if (dut.state_q !== S_IDLE || dut.rr_ptr_q !== 2'd0) begin
            failures++;
            $display("FAIL rst_async_state got state=%0d rr_ptr=%0d required 0/0", dut.state_q, dut.rr_ptr_q);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_grant(10, g, t);
        checks++;
        if (g !== 4'b0001 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_regrant got ready=%b busy=%b required 0001/0", g, busy);
        end
        push_row(0, 7, t);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_grant(300, g, t);
        checks++;
        if (g !== 4'b0100) begin
            failures++;
            $display("FAIL rst_second_grant got ready=%b required 0100", g);
        end
        push_row(2, 9, t);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rst_drain got pending=%0d busy=%b required 0/0", q.size(), busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_four_simultaneous();
        test_fairness();
        test_error_boundary();
        test_reset_mid_burst();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pos_rom_row_arbiter.md
Name: pos_rom_row_arbiter

Overview:
- Shares one synchronous FP16 positional-embedding ROM (1-cycle read latency) among NUM_REQ requesters.
- Requesters are positional-encoding adder lanes or a prefetch engine. Each request asks for one full token row (E values).
- Round-robin grant per row; the arbiter then streams the dim addresses to the ROM and returns a tagged response stream.
- Sits between the adder datapaths and the ROM. It is the only block that drives the ROM address.

Parameters:
- DATA_WIDTH, 16, bit width of each ROM element.
- NUM_TOKENS, 196, ROM row count; valid token indices are 0..NUM_TOKENS-1.
- E, 128, embedding dimension; elements per row.
- NUM_REQ, 4, number of requesters (at least 2).
- Derived, not overridable: TOK_W=$clog2(NUM_TOKENS), DIM_W=$clog2(E), ID_W=max(1,$clog2(NUM_REQ)).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester row request
- req_token  in  NUM_REQ*TOK_W  requested token index; requester r occupies bits [r*TOK_W +: TOK_W]
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted on a cycle where valid and ready are both high
- rom_token_idx  out  TOK_W  ROM row address
- rom_dim  out  DIM_W  ROM column address
- rom_pos_val  in  DATA_WIDTH  ROM data, valid one cycle after the address
- rsp_valid  out  1  response beat valid (no backpressure)
- rsp_id  out  ID_W  requester the beat belongs to
- rsp_dim  out  DIM_W  dim index of the beat
- rsp_data  out  DATA_WIDTH  positional value
- rsp_last  out  1  final beat of the row
- rsp_err  out  1  beat is an error beat
- busy  out  1  high in any state other than S_IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state S_IDLE, rr_ptr=0, all counters 0, every output 0.
- Reset mid-burst abandons the row: no further rsp beats and no rsp_last. Requesters reissue their requests.

States:
- S_IDLE
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - First set bit wins. req_ready[winner] goes high combinationally in this cycle only.
  - On the grant edge, latch the winner's token and id, and set rr_ptr=(winner+1)%NUM_REQ.
  - If the token is < NUM_TOKENS, go to S_BURST with dim=0; otherwise go to S_ERR.
  - If no req_valid is set, stay in S_IDLE and all req_ready bits stay 0.
- S_BURST
  - rom_token_idx = latched token; rom_dim = dim. dim increments every cycle.
  - When dim==E-1, go to S_DRAIN.
- S_DRAIN
  - One cycle that collects the last ROM word, then return to S_IDLE.
- S_ERR
  - One cycle: rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0, rsp_dim=0, rsp_id = latched id.
  - Then return to S_IDLE. The ROM is not addressed.

Response path:
- Registered issue_vld, dim_dly and id_dly track the addressed beat.
- rsp_valid = issue_vld; rsp_data = rom_pos_val, passed combinationally from the ROM register.
- rsp_last = issue_vld and dim_dly==E-1.
- rsp_err is 0 except in S_ERR.

Timing:
- Request seen in cycle t gets req_ready in cycle t. The first beat (dim 0) appears in cycle t+2; the last beat in cycle t+E+1.
- The next grant is possible at t+E+2, so row period = E+2 cycles. An error request occupies 2 cycles.

Addressing and handshake rules:
- Outside S_BURST, rom_token_idx and rom_dim hold 0.
- Requesters keep req_valid and req_token stable until they are granted. Dropping req_valid before the grant is legal; that requester is simply skipped.
- Re-asserting req_valid in the same cycle as its own grant is treated as a new request, evaluated in the next S_IDLE.
- Simultaneous requests are resolved by rr_ptr only. No requester waits more than NUM_REQ-1 rows.

Decomposition:
- Package pos_enc_pkg holds: arb_state_t (S_IDLE, S_BURST, S_DRAIN, S_ERR), a width helper function, and the default localparams DATA_WIDTH, NUM_TOKENS, E.
- Sub-module rr_arbiter: combinational round-robin pick, parameterised by N. Inputs: request vector and pointer. Outputs: one-hot grant and encoded index.
- The FSM, counters and response pipeline stay in pos_rom_row_arbiter.

Test Plan:
- Single request: req_valid[0]=1, token 5, ROM model value = {token,dim} → req_ready[0] in cycle 0; 128 beats in cycles 2..129 with rsp_id=0, rsp_dim 0..127, rsp_data=(5<<7)|dim; rsp_last only at cycle 129; busy low at cycle 130.
- Four simultaneous requests with tokens 10, 20, 30, 40, held until granted → grants in order 0,1,2,3, each 130 cycles apart; every row is contiguous and never interleaved.
- Fairness: requesters 1 and 3 request continuously for 6 rows → grants alternate 1,3,1,3,1,3; rr_ptr after each grant equals winner+1.
- Out-of-range request: requester 2, token 196 → one beat with rsp_err=1, rsp_last=1, rsp_id=2, rsp_data=0; rom_token_idx stays 0; next grant 2 cycles after accept.
- Boundary row: token 195 → rom_token_idx=195 for all 128 burst cycles; last beat is dim 127 with rsp_last=1.
- Reset mid-burst: rst_n pulled low at beat 50 → all outputs 0 immediately (asynchronous); after release, state is S_IDLE, rr_ptr=0, and a pending request on requester 0 is granted first.
